perf_monitor: RTL

Synthesisable performance-counter and end-of-run controller for the ARM32 cache pipeline. It replaces bench-side cycle/instruction counting with an in-design block. It counts cycles, retired instructions and N generic events such as cache hits, misses and stalls, all with saturating counters. After a stop request it runs a fixed pipeline-drain window, then flags completion. Results are read through a selectable read port, so benches and debug logic get cycle-exact numbers for CPI and hit-rate computation.

---
 rtl/perf_monitor.sv | 94 +++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: saturating cycle/instruction/event counters with a fixed post-stop drain window.
module perf_monitor #(
    parameter int CNT_W        = 32,
    parameter int N_EVT        = 4,
    parameter int DRAIN_CYCLES = 20,
    parameter int SEL_W        = $clog2(N_EVT + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic               en,
    input  logic               inst_retire,
    input  logic [N_EVT-1:0]   evt,
    input  logic [SEL_W-1:0]   sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [N_EVT+1:0]   ovf,
    output logic               busy,
    output logic               draining,
    output logic               done
);
    localparam int NC = N_EVT + 2;
    // A one-cycle drain window still needs a one-bit counter.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [DW-1:0]     dcnt, dcnt_nx;
    logic [CNT_W-1:0]  cnt [NC];
    logic [NC-1:0]     inc;
    logic              active;

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN: begin
                if (start) state_nx = RUN;
                else if (stop_req) begin
                    state_nx = DRAIN;
                    dcnt_nx  = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (start) state_nx = RUN;
                else if (dcnt == '0) state_nx = DONE;
                else dcnt_nx = dcnt - DW'(1);
            end
            default: state_nx = start ? RUN : DONE;
        endcase
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign draining = state == DRAIN;
    assign done     = state == DONE;

    always_comb begin
        inc    = '0;
        active = en && !start;
        inc[0] = active && state == RUN;
        inc[1] = active && busy && inst_retire;
        for (int i = 0; i < N_EVT; i++) inc[i+2] = active && busy && evt[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            ovf   <= '0;
            for (int i = 0; i < NC; i++) cnt[i] <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            if (start) begin
                ovf <= '0;
                for (int i = 0; i < NC; i++) cnt[i] <= '0;
            end else begin
                for (int i = 0; i < NC; i++)
                    if (inc[i]) begin
                        if (&cnt[i]) ovf[i] <= 1'b1;
                        else cnt[i] <= cnt[i] + CNT_W'(1);
                    end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NC; i++)
            if (sel == SEL_W'(i)) rd_data = cnt[i];
    end
endmodule
